// File: rtl/div_unit.sv
// rtl/div_unit.sv - RV32M multi-cycle restoring divider (DIV/DIVU/REM/REMU) with pipeline stall request
// Optional macro DIV_EARLY_OUT_EN: skip iteration for divide-by-zero, signed overflow and |dividend| < |divisor|.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [XLEN-1:0] q, rem, dvs_q, dvd_q;
    logic [CW-1:0]   count;
    logic            rem_op, q_neg, r_neg, dz_q, ovf_q;

    // Operand conditioning for the accept cycle
    logic            op_signed, dvd_neg, dvs_neg, in_dz, in_ovf, accept, early, last;
    logic [XLEN-1:0] dvd_mag, dvs_mag;

    assign op_signed = ~op[0];
    assign dvd_neg   = op_signed & dividend[XLEN-1];
    assign dvs_neg   = op_signed & divisor[XLEN-1];
    assign dvd_mag   = dvd_neg ? -dividend : dividend;
    assign dvs_mag   = dvs_neg ? -divisor : divisor;
    assign in_dz     = (divisor == '0);
    assign in_ovf    = op_signed & (dividend == MIN_NEG) & (divisor == '1);
    assign accept    = (state == IDLE) & start & ~flush;
    assign last      = (count == CW'(XLEN - 1));

`ifdef DIV_EARLY_OUT_EN
    assign early = in_dz | in_ovf | (dvd_mag < dvs_mag);
`else
    assign early = 1'b0;
`endif

    // One restoring step: XLEN+1 bit subtract so the borrow is the compare result
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] q_step, rem_step;

    assign rem_sh   = {rem, q[XLEN-1]};
    assign diff     = rem_sh - {1'b0, dvs_q};
    assign q_step   = {q[XLEN-2:0], ~diff[XLEN]};
    assign rem_step = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];

    function automatic logic [XLEN-1:0] fixup(
        input logic            is_rem,
        input logic            neg_quo,
        input logic            neg_rem,
        input logic            dz,
        input logic            ovf,
        input logic [XLEN-1:0] qm,
        input logic [XLEN-1:0] rm,
        input logic [XLEN-1:0] dvd
    );
        if (dz)
            return is_rem ? dvd : '1;
        else if (ovf)
            return is_rem ? '0 : MIN_NEG;
        else if (is_rem)
            return neg_rem ? -rm : rm;
        else
            return neg_quo ? -qm : qm;
    endfunction

    always_comb begin
        state_nxt = state;
        stall_req = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    stall_req = 1'b1;
                    state_nxt = early ? DONE : CALC;
                end
            end
            CALC: begin
                stall_req = 1'b1;
                if (flush)
                    state_nxt = IDLE;
                else if (last)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= '0;
            rem    <= '0;
            dvs_q  <= '0;
            dvd_q  <= '0;
            count  <= '0;
            rem_op <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
            result <= '0;
        end else if (accept) begin
            q      <= dvd_mag;
            rem    <= '0;
            dvs_q  <= dvs_mag;
            dvd_q  <= dividend;
            count  <= '0;
            rem_op <= op[1];
            q_neg  <= dvd_neg ^ dvs_neg;
            r_neg  <= dvd_neg;
            dz_q   <= in_dz;
            ovf_q  <= in_ovf;
            if (early)
                result <= fixup(op[1], dvd_neg ^ dvs_neg, dvd_neg, in_dz, in_ovf,
                                '0, dvd_mag, dividend);
        end else if (state == CALC && !flush) begin
            q     <= q_step;
            rem   <= rem_step;
            count <= count + 1'b1;
            if (last)
                result <= fixup(rem_op, q_neg, r_neg, dz_q, ovf_q, q_step, rem_step, dvd_q);
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit; done pulses are checked against queued expectations
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend, divisor;
    logic        flush;
    logic        stall_req, busy, done;
    logic [31:0] result;

    div_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .dividend(dividend), .divisor(divisor), .flush(flush),
        .stall_req(stall_req), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] last_result;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, result, e.res);
                chk({e.name, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit early_case, input string nm,
                          input bit poke);
        int lat;
        lat = 33;
`ifdef DIV_EARLY_OUT_EN
        if (early_case) lat = 1;
`else
        if (early_case) lat = 33;
`endif
        @(posedge clk); #1;
        start = 1'b1; op = o; dividend = a; divisor = b;
        sb.push_back('{exp, cyc + lat, nm});
        #1 chk({nm, "_stall0"}, {31'b0, stall_req}, 32'd1);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (poke && k == 3 && lat > 4) begin
                start = 1'b1; op = 2'd0; dividend = ~a; divisor = b + 32'd1;
            end
            if (poke && k == 4) start = 1'b0;
            #1;
            chk({nm, "_stall"}, {31'b0, stall_req}, (k < lat) ? 32'd1 : 32'd0);
            chk({nm, "_busy"}, {31'b0, busy}, 32'd1);
        end
        @(posedge clk); #2;
        chk({nm, "_idle"}, {31'b0, busy}, 32'd0);
        chk({nm, "_hold"}, result, exp);
        last_result = exp;
    endtask

    initial begin
        int c;
        rst_n = 1'b0; start = 1'b0; op = 2'd0; dividend = '0; divisor = '0; flush = 1'b0;
        last_result = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_stall", {31'b0, stall_req}, 32'd0);
        rst_n = 1'b1;

        run_op(2'd1, 32'd100, 32'd7, 32'd14, 1'b0, "divu_100_7", 1'b0);
        run_op(2'd3, 32'd100, 32'd7, 32'd2, 1'b0, "remu_100_7", 1'b1);
        run_op(2'd0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, "div_m7_2", 1'b0);
        run_op(2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, "rem_m7_2", 1'b0);
        run_op(2'd0, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, "div_7_m2", 1'b0);
        run_op(2'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 1'b0, "rem_7_m2", 1'b0);
        run_op(2'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1'b0, "divu_max_1", 1'b0);
        run_op(2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div_ovf", 1'b0);
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1, "rem_ovf", 1'b0);
        run_op(2'd1, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, "divu_5_0", 1'b0);
        run_op(2'd3, 32'd5, 32'd0, 32'd5, 1'b1, "remu_5_0", 1'b0);
        run_op(2'd0, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1'b1, "div_m7_0", 1'b0);
        run_op(2'd1, 32'd3, 32'd10, 32'd0, 1'b1, "divu_3_10", 1'b0);
        run_op(2'd3, 32'd3, 32'd10, 32'd3, 1'b1, "remu_3_10", 1'b0);

        // Flush in the middle of an iteration, then restart
        @(posedge clk); #1;
        start = 1'b1; op = 2'd1; dividend = 32'd1000; divisor = 32'd3;
        c = cyc;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        #1 chk("flush_cycle", cyc, c + 10);
        @(posedge clk); #1 flush = 1'b0;
        #1;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_stall", {31'b0, stall_req}, 32'd0);
        chk("flush_result", result, last_result);
        run_op(2'd1, 32'd1000, 32'd3, 32'd333, 1'b0, "divu_1000_3", 1'b0);

        // Start together with flush in IDLE is ignored
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = 2'd1; dividend = 32'd9; divisor = 32'd2;
        #1 chk("flush_start_stall", {31'b0, stall_req}, 32'd0);
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        #1 chk("flush_start_busy", {31'b0, busy}, 32'd0);

        // Reset mid-operation
        @(posedge clk); #1;
        start = 1'b1; op = 2'd0; dividend = 32'hFFFFFFF9; divisor = 32'd2;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_busy", {31'b0, busy}, 32'd0);
        chk("rstmid_done", {31'b0, done}, 32'd0);
        chk("rstmid_result", result, 32'd0);
        start = 1'b1;
        @(posedge clk); #2;
        chk("rstmid_start_ignored", {31'b0, busy}, 32'd0);
        start = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        last_result = '0;
        run_op(2'd1, 32'd100, 32'd7, 32'd14, 1'b0, "post_rst_divu", 1'b0);

        repeat (3) @(posedge clk);
        #1 chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle RV32M divider in the EX stage. Handles DIV, DIVU, REM and REMU using radix-2 restoring division, one quotient bit per cycle.
- Produces the stall request that the pipeline hazard logic ORs into its PC, IF/ID and ID/EX hold controls, freezing the front end while a divide is in flight.
- Returns a one-cycle result pulse for EX writeback selection.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous reset, active low
- start  input  1  EX holds a divide op; sampled only in IDLE
- op  input  2  0=DIV, 1=DIVU, 2=REM, 3=REMU; latched on accepted start
- dividend  input  XLEN  rs1 value; latched on accepted start
- divisor  input  XLEN  rs2 value; latched on accepted start
- flush  input  1  control-hazard flush of EX; aborts operation
- stall_req  output  1  hold pipeline (combinational)
- busy  output  1  state != IDLE (registered)
- done  output  1  result valid, one-cycle pulse (registered)
- result  output  XLEN  quotient or remainder per latched op

Behaviour:
- Reset: asynchronous, active-low. state=IDLE; busy=0, done=0, result=0; internal quotient, remainder, counter and latched op/sign flags all 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and flush=0 → latch op and operands, compute magnitudes, go to CALC with count=0.
  - For signed ops, magnitude = two's-complement negate when bit XLEN-1 is set; unsigned ops use raw values.
- CALC:
  - Each edge: rem = {rem[XLEN-2:0], q[XLEN-1]}, q <<= 1. If rem >= divisor magnitude, subtract and set q[0]=1. count++.
  - Arithmetic runs at XLEN+1 bits internally so the compare is unsigned and overflow-free.
  - After the XLEN-th iteration → DONE. The result is fixed up on that same edge.
- Sign fixup:
  - Quotient negated if dividend and divisor signs differ (signed ops only).
  - Remainder takes the dividend's sign.
- Special cases override the fixup:
  - Divisor==0: quotient=all ones, remainder=original dividend (all four ops).
  - Signed overflow (dividend=0x80000000, divisor=0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0.
- DONE: done=1 for exactly one cycle, result valid, busy=1 → IDLE next edge.
- result holds its value after DONE until the next accepted start.
- stall_req = (state==IDLE & start & ~flush) | (state==CALC). It is 0 in DONE, so the stalled op advances out of EX in the cycle its result is valid.
- Latency: start in cycle 0 → done in cycle XLEN+1 (cycle 33 by default).
- start while busy: ignored. Operands are not re-sampled.
- flush:
  - In any state, returns to IDLE at the next edge. done is not asserted, and result keeps its previous value.
  - flush with start in IDLE: start is ignored and stall_req=0.
  - flush in DONE: the done pulse already emitted stands, but the hazard logic discards it.
- Reset mid-operation: immediate return to reset values. No done is issued.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - Divisor==0, signed overflow, and unsigned dividend magnitude < divisor magnitude skip CALC.
  - IDLE goes directly to DONE with the final result, so done appears in cycle 1 after start.
  - stall_req is high only in the start cycle.
- Undefined:
  - Every op runs the full XLEN iterations; done appears in cycle XLEN+1.
  - Special-case result values are identical in both builds.

Test Plan:
- DIVU 100/7, start pulse in cycle 0 → stall_req high cycles 0–32, done in cycle 33, result=14. Then REMU same operands → result=2.
- DIV 0xFFFFFFF9 (-7)/2 → result=0xFFFFFFFD (-3). REM same operands → result=0xFFFFFFFF (-1).
- DIV 0x80000000/0xFFFFFFFF → result=0x80000000. REM → 0. DIVU 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. DIV 0xFFFFFFF9/0 → 0xFFFFFFFF.
- Start DIVU 1000/3, assert flush in cycle 10 → busy=0 and stall_req=0 in cycle 11, no done, result unchanged. A new start in cycle 12 yields 333 in cycle 45.
- Start DIV, drop rst_n in cycle 5 → busy, done and result=0 immediately. start is ignored until rst_n rises, then operates normally.
- With DIV_EARLY_OUT_EN: DIVU 3/10 → done in cycle 1, result=0. REMU → 3. Without the macro, done in cycle 33 with the same values.
